data_burst_ctrl: RTL and testbench
==================================

# data_burst_ctrl

Burst-side engine of the APB-to-burst bridge. It sits opposite the register bank on the `db_rb_*` / `rb_db_*` interface:
- It accepts the start pulse, length, max burst size and direction from the register bank.
- It moves `length` bytes between register-bank locations 0..length-1 and an external burst bus, split into bursts of at most `max_burst_size` beats.
- It reports idle and read completion back to the register bank.

## Interface
- `DATA_W`, 8, data width of the register bank and burst bus
- `ADDR_W`, 9, register-bank address width
- `TIMEOUT_CYCLES`, 255, wait limit per beat for `bus_ready` (used only with `DB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rb_db_start`  in  1  one-cycle start pulse from the register bank
- `rb_db_length`  in  8  total bytes to move
- `rb_db_max_burst_size`  in  8  max beats per burst; 0 is treated as 1
- `rb_db_rw`  in  1  1 = write to bus (RB → bus), 0 = read from bus (bus → RB)
- `rb_db_data`  in  8  RB read data, valid in the same cycle as `db_rb_req` when `rb_db_rw`=1
- `rb_db_ack`  in  1  RB acknowledge, equal to `db_rb_req`
- `db_rb_req`  out  1  RB access strobe
- `db_rb_addr`  out  9  RB location, 0..length-1
- `db_rb_data`  out  8  data to write into the RB (read direction)
- `db_rb_idle`  out  1  high when the FSM is in IDLE
- `db_rb_rd_done`  out  1  one-cycle pulse at the end of a read transaction
- `bus_valid`  out  1  beat valid
- `bus_start`  out  1  high with `bus_valid` on the first beat of each burst
- `bus_rw`  out  1  direction, stable for the whole transaction
- `bus_len`  out  8  beats in the current burst, stable from `bus_start` until the last beat
- `bus_wdata`  out  8  write beat data
- `bus_rdata`  in  8  read beat data, sampled when `bus_valid & bus_ready`
- `bus_ready`  in  1  slave accepts the beat
- `db_err`  out  1  one-cycle timeout pulse; tied 0 without `DB_TIMEOUT_EN`

## Operation
- **FSM states:** IDLE, LOAD, FETCH, WBEAT, RBEAT, RBWR, GAP, DONE.
- **IDLE:** `db_rb_idle`=1. Sampling `rb_db_start`=1 captures length L, max burst size M (0→1) and rw, then goes to LOAD. Start pulses outside IDLE are ignored.
- **LOAD:**
  - If L==0 → DONE.
  - Otherwise burst size B = min(remaining, M); addr=0 on the first LOAD.
  - rw=1 → FETCH; rw=0 → RBEAT.
- **Write beat:**
  - FETCH: `db_rb_req`=1 with `db_rb_addr`=addr; `rb_db_data` is registered into `bus_wdata`.
  - WBEAT: `bus_valid`=1, held until `bus_ready`.
  - On handshake: addr+1, remaining-1, beat count-1.
- **Read beat:**
  - RBEAT: `bus_valid`=1 until `bus_ready`; `bus_rdata` is captured.
  - RBWR: `db_rb_req`=1 with `db_rb_addr`=addr and `db_rb_data`=captured byte. Counters update as in the write beat.
- **After a beat:**
  - Burst beats left → FETCH/RBEAT.
  - Burst exhausted and remaining>0 → GAP (one cycle, `bus_valid`=0) → LOAD.
  - remaining==0 → DONE.
- **DONE:** one cycle. `db_rb_rd_done`=1 if rw=0 (including L==0 reads). Then → IDLE.
- **Arithmetic:** remaining and beat counters are 9-bit; `db_rb_addr` = {1'b0, addr[7:0]}, so it never reaches 256.

## Timing
- **Reset values:** FSM=IDLE. `db_rb_idle`=1. All other outputs 0, including `bus_len` and `bus_wdata`.
- **Reset mid-transfer:** return to IDLE immediately; no `rd_done`, no `db_err`.
- **Start latency:** start sampled in cycle 0 → LOAD in cycle 1 → first `bus_valid` in cycle 3 (write) or cycle 2 (read).
- **Throughput:** 2 cycles per beat with zero-wait `bus_ready`, plus 2 cycles (GAP+LOAD) between bursts.
- **Handshake:** `bus_valid` never drops before `bus_ready`. `bus_wdata`, `bus_start` and `bus_len` are stable while waiting.
- **Register-bank side:** `db_rb_req` is always exactly one cycle per byte. `db_rb_idle` drops the cycle after start is sampled and rises the cycle after DONE.

## Configuration
- **Macro `DB_TIMEOUT_EN`:**
  - Defined: a per-beat wait counter, cleared on each handshake. When it reaches `TIMEOUT_CYCLES` while waiting in WBEAT/RBEAT, `db_err` pulses for one cycle, the FSM aborts to DONE, and `rd_done` is suppressed.
  - Undefined: no counter; waits forever; `db_err`=0.

## Structure
- **Shared package `burst_pkg`:**
  - state typedef
  - `DATA_W` / `ADDR_W` defaults
  - `RB_DATA_DEPTH`=256
- **Sub-module `burst_splitter`:** combinational plus registered computation of B = min(remaining, M_eff) and the last-beat/last-burst flags.

## Test plan
- L=4, M=4, rw=1, RB[0..3]=A0..A3, `bus_ready` always high → one burst, `bus_start` on beat 0, `bus_len`=4, `bus_wdata` A0,A1,A2,A3, 4 `db_rb_req` at addr 0..3, no `rd_done`.
- L=5, M=2, rw=0, `bus_rdata`=10,11,12,13,14 → bursts of 2,2,1 with a GAP between each; RB writes at addr 0..4 with 10..14; one `db_rb_rd_done` pulse.
- M=0, L=3, rw=1 → three 1-beat bursts, `bus_len`=1 each.
- L=0, rw=0 → LOAD, DONE, `rd_done` pulse; `bus_valid` never asserted; idle low for exactly 3 cycles.
- `bus_ready` held low 6 cycles on beat 1 → `bus_valid` and `bus_wdata` stable; completes normally. With `DB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4 → `db_err` pulse, then IDLE.
- `rst_n` asserted mid-burst → all outputs at reset values asynchronously; a new start after release runs from addr 0.

Source files
------------

// File: rtl/burst_pkg.sv
// burst_pkg: types and constants shared by the burst engine files.
//   state_t        - burst engine FSM state encoding
//   DEF_DATA_W     - default data width of register bank and burst bus
//   DEF_ADDR_W     - default register-bank address width
//   RB_DATA_DEPTH  - number of addressable register-bank data locations
package burst_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 9;
  localparam int RB_DATA_DEPTH = 256;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_WBEAT = 3'd3,
    S_RBEAT = 3'd4,
    S_RBWR  = 3'd5,
    S_GAP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/burst_splitter.sv
// burst_splitter: sizes the next burst and flags the end of a burst / transfer.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - FSM is in LOAD; latches the new burst length
//   remaining    - bytes still to move in the transaction
//   max_beats    - effective max burst size (already 1..255)
//   beats_left   - beats still to move in the current burst
//   burst_size   - min(remaining, max_beats), combinational
//   burst_len    - registered burst length presented on bus_len
//   last_beat    - current beat is the final beat of its burst
//   last_byte    - current beat is the final byte of the transaction
module burst_splitter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [8:0] remaining,
  input  logic [7:0] max_beats,
  input  logic [8:0] beats_left,
  output logic [8:0] burst_size,
  output logic [7:0] burst_len,
  output logic       last_beat,
  output logic       last_byte
);

  // Burst size and end-of-burst / end-of-transfer flags from the live counters
  always_comb begin
    if (remaining < {1'b0, max_beats}) begin
      burst_size = remaining;
    end else begin
      burst_size = {1'b0, max_beats};
    end
    last_beat = (beats_left == 9'd1);
    last_byte = (remaining == 9'd1);
  end

  // Hold the burst length from LOAD until the next LOAD; a zero-length LOAD keeps it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_len <= 8'd0;
    end else if (load && (remaining != 9'd0)) begin
      burst_len <= burst_size[7:0];
    end
  end

endmodule

// File: rtl/data_burst_ctrl.sv
// data_burst_ctrl: burst-side engine of the APB-to-burst bridge.
// Moves rb_db_length bytes between register-bank locations 0..length-1 and the
// burst bus, in bursts of at most rb_db_max_burst_size beats (0 counts as 1).
//   rb_db_*  - start/length/max burst/direction, RB read data and acknowledge
//   db_rb_*  - RB access strobe, address, write data, idle, read-done pulse
//   bus_*    - burst bus: valid/start/rw/len/wdata out, rdata/ready in
//   db_err   - one-cycle pulse when a beat waits too long for bus_ready
// Optional feature macro DB_TIMEOUT_EN: enables the per-beat bus_ready wait
// limit TIMEOUT_CYCLES; without it the engine waits indefinitely and db_err=0.
import burst_pkg::*;

module data_burst_ctrl #(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rb_db_start,
  input  logic [7:0]        rb_db_length,
  input  logic [7:0]        rb_db_max_burst_size,
  input  logic              rb_db_rw,
  input  logic [DATA_W-1:0] rb_db_data,
  input  logic              rb_db_ack,
  output logic              db_rb_req,
  output logic [ADDR_W-1:0] db_rb_addr,
  output logic [DATA_W-1:0] db_rb_data,
  output logic              db_rb_idle,
  output logic              db_rb_rd_done,
  output logic              bus_valid,
  output logic              bus_start,
  output logic              bus_rw,
  output logic [7:0]        bus_len,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              db_err
);

  localparam int AW = $clog2(RB_DATA_DEPTH);

  state_t        state;
  logic [8:0]    remaining;
  logic [8:0]    beats_left;
  logic [7:0]    max_beats;
  logic [AW-1:0] addr;
  logic          first_beat;
  logic [8:0]    burst_size;
  logic          last_beat;
  logic          last_byte;
  logic          timeout_hit;

  burst_splitter u_splitter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == S_LOAD),
    .remaining  (remaining),
    .max_beats  (max_beats),
    .beats_left (beats_left),
    .burst_size (burst_size),
    .burst_len  (bus_len),
    .last_beat  (last_beat),
    .last_byte  (last_byte)
  );

  // The address counter wraps within the RB data window, so bit 8 stays 0
  assign db_rb_addr = {{(ADDR_W-AW){1'b0}}, addr};

`ifdef DB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_pulse;

  // Wait cycles of the current beat; any handshake or state change clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 16'd0;
    end else if (((state == S_WBEAT) || (state == S_RBEAT)) && !bus_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end

  assign timeout_hit = ((state == S_WBEAT) || (state == S_RBEAT)) && !bus_ready &&
                       (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Error pulse coincides with the DONE cycle of the aborted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= timeout_hit;
    end
  end

  assign db_err = err_pulse;
`else
  // No wait limit: a non-negative TIMEOUT_CYCLES can never trigger an abort
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign db_err      = 1'b0;
`endif

  // Main transfer FSM with all bus and RB-side outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      remaining     <= 9'd0;
      beats_left    <= 9'd0;
      max_beats     <= 8'd0;
      addr          <= {AW{1'b0}};
      first_beat    <= 1'b0;
      db_rb_req     <= 1'b0;
      db_rb_data    <= {DATA_W{1'b0}};
      db_rb_idle    <= 1'b1;
      db_rb_rd_done <= 1'b0;
      bus_valid     <= 1'b0;
      bus_start     <= 1'b0;
      bus_rw        <= 1'b0;
      bus_wdata     <= {DATA_W{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          if (rb_db_start) begin
            remaining  <= {1'b0, rb_db_length};
            max_beats  <= (rb_db_max_burst_size == 8'd0) ? 8'd1 : rb_db_max_burst_size;
            bus_rw     <= rb_db_rw;
            addr       <= {AW{1'b0}};
            db_rb_idle <= 1'b0;
            state      <= S_LOAD;
          end else begin
            db_rb_idle <= 1'b1;
          end
        end

        S_LOAD: begin
          if (remaining == 9'd0) begin
            db_rb_rd_done <= !bus_rw;
            state         <= S_DONE;
          end else begin
            beats_left <= burst_size;
            first_beat <= 1'b1;
            if (bus_rw) begin
              db_rb_req <= 1'b1;
              state     <= S_FETCH;
            end else begin
              bus_valid <= 1'b1;
              bus_start <= 1'b1;
              state     <= S_RBEAT;
            end
          end
        end

        // RB read data arrives in the same cycle as the strobe
        S_FETCH: begin
          if (rb_db_ack) begin
            db_rb_req <= 1'b0;
            bus_wdata <= rb_db_data;
            bus_valid <= 1'b1;
            bus_start <= first_beat;
            state     <= S_WBEAT;
          end
        end

        S_WBEAT: begin
          if (bus_ready) begin
            bus_valid  <= 1'b0;
            bus_start  <= 1'b0;
            first_beat <= 1'b0;
            addr       <= addr + AW'(1);
            remaining  <= remaining - 9'd1;
            beats_left <= beats_left - 9'd1;
            if (!last_beat) begin
              db_rb_req <= 1'b1;
              state     <= S_FETCH;
            end else if (!last_byte) begin
              state <= S_GAP;
            end else begin
              state <= S_DONE;
            end
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            bus_start <= 1'b0;
            state     <= S_DONE;
          end
        end

        S_RBEAT: begin
          if (bus_ready) begin
            bus_valid  <= 1'b0;
            bus_start  <= 1'b0;
            first_beat <= 1'b0;
            db_rb_data <= bus_rdata;
            db_rb_req  <= 1'b1;
            state      <= S_RBWR;
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            bus_start <= 1'b0;
            state     <= S_DONE;
          end
        end

        S_RBWR: begin
          if (rb_db_ack) begin
            db_rb_req  <= 1'b0;
            addr       <= addr + AW'(1);
            remaining  <= remaining - 9'd1;
            beats_left <= beats_left - 9'd1;
            if (!last_beat) begin
              bus_valid <= 1'b1;
              state     <= S_RBEAT;
            end else if (!last_byte) begin
              state <= S_GAP;
            end else begin
              db_rb_rd_done <= 1'b1;
              state         <= S_DONE;
            end
          end
        end

        S_GAP: begin
          state <= S_LOAD;
        end

        S_DONE: begin
          db_rb_rd_done <= 1'b0;
          state         <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_burst_ctrl.sv
`timescale 1ns/1ps
module tb_data_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rb_db_start = 1'b0;
  logic [7:0] rb_db_length = 8'd0;
  logic [7:0] rb_db_max_burst_size = 8'd0;
  logic       rb_db_rw = 1'b0;
  logic [7:0] rb_db_data;
  logic       rb_db_ack;
  logic       db_rb_req;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_idle;
  logic       db_rb_rd_done;
  logic       bus_valid;
  logic       bus_start;
  logic       bus_rw;
  logic [7:0] bus_len;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 8'd0;
  logic       bus_ready = 1'b0;
  logic       db_err;

`ifdef DB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  data_burst_ctrl #(.DATA_W(8), .ADDR_W(9), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rb_db_start(rb_db_start), .rb_db_length(rb_db_length),
    .rb_db_max_burst_size(rb_db_max_burst_size), .rb_db_rw(rb_db_rw),
    .rb_db_data(rb_db_data), .rb_db_ack(rb_db_ack),
    .db_rb_req(db_rb_req), .db_rb_addr(db_rb_addr), .db_rb_data(db_rb_data),
    .db_rb_idle(db_rb_idle), .db_rb_rd_done(db_rb_rd_done),
    .bus_valid(bus_valid), .bus_start(bus_start), .bus_rw(bus_rw),
    .bus_len(bus_len), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .db_err(db_err)
  );

  always #5 clk = ~clk;

  // Register bank model: combinational read, ack mirrors the strobe
  logic [7:0] rb_mem [256];
  logic [7:0] rd_src [256];
  assign rb_db_data = rb_mem[db_rb_addr[7:0]];
  assign rb_db_ack  = db_rb_req;

  typedef struct packed {
    logic       rw;
    logic       st;
    logic [7:0] len;
    logic [7:0] data;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t beats[$];
  logic [16:0] rb_acc[$];
  int    waits, rd_dones, errs, idle_low, stab_err, first_valid;
  int    ready_mode = 0;
  int    stall_left = 0;
  bit    cur_rw = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus slave: ready pattern and read data for the next beat
  initial begin
    int consec;
    consec = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus_ready = 1'b1;
      end else if (ready_mode == 1) begin
        bus_ready = (consec >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else begin
        if (bus_valid && (beats.size() == 1) && (stall_left > 0)) begin
          bus_ready = 1'b0;
          stall_left--;
        end else begin
          bus_ready = 1'b1;
        end
      end
      consec = (bus_valid && !bus_ready) ? consec + 1 : 0;
      bus_rdata = rd_src[beats.size() % 256];
    end
  end

  // Monitor: record beats, RB accesses, pulses and handshake stability
  initial begin
    bit    pend;
    beat_t pend_b;
    beat_t b;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      b = '{rw: bus_rw, st: bus_start, len: bus_len, data: bus_wdata};
      if (pend && (!bus_valid || (b != pend_b))) stab_err++;
      pend = 1'b0;
      if (bus_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (bus_ready) begin
          beats.push_back(b);
        end else begin
          waits++;
          pend   = 1'b1;
          pend_b = b;
        end
      end
      if (db_rb_req) rb_acc.push_back({db_rb_addr, cur_rw ? rb_db_data : db_rb_data});
      if (db_rb_rd_done) rd_dones++;
      if (db_err) errs++;
      if (!db_rb_idle) idle_low++;
    end
  end

  task automatic clear_mon();
    beats.delete();
    rb_acc.delete();
    waits = 0; rd_dones = 0; errs = 0; idle_low = 0; stab_err = 0; first_valid = -1;
  endtask

  task automatic check_reset_vals();
    check("rst_idle", db_rb_idle, 1);
    check("rst_req", db_rb_req, 0);
    check("rst_addr", db_rb_addr, 0);
    check("rst_rbdata", db_rb_data, 0);
    check("rst_rd_done", db_rb_rd_done, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_start", bus_start, 0);
    check("rst_rw", bus_rw, 0);
    check("rst_len", bus_len, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_err", db_err, 0);
  endtask

  // One transaction checked against arithmetic derived from the transfer rules
  task automatic run_txn(input int L, input int M, input bit rw, input int mode,
                         input int stall, input bit pattern, input bit abort);
    int meff, nb, exp_idle, blen, start_cyc;
    bit done;
    beat_t b;
    @(posedge clk);
    #3;
    for (int i = 0; i < 256; i++) begin
      rb_mem[i] = pattern ? 8'(8'hA0 + i) : 8'($urandom);
      rd_src[i] = pattern ? 8'(8'd10 + i) : 8'($urandom);
    end
    clear_mon();
    ready_mode = mode;
    stall_left = stall;
    cur_rw = rw;
    rb_db_length = 8'(L);
    rb_db_max_burst_size = 8'(M);
    rb_db_rw = rw;
    rb_db_start = 1'b1;
    @(posedge clk);
    #3;
    start_cyc = cyc - 1;
    rb_db_start = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (db_rb_idle) begin
        done = 1'b1;
        break;
      end
    end
    check("txn_complete", done, 1);
    @(posedge clk);
    #3;
    if (abort) begin
      check("abort_err", errs, 1);
      check("abort_rd_done", rd_dones, 0);
      check("abort_beats", beats.size(), 1);
    end else begin
      meff = (M == 0) ? 1 : M;
      nb = (L + meff - 1) / meff;
      exp_idle = (L == 0) ? 3 : (2 * nb + 2 * L + 1 + waits);
      check("beat_count", beats.size(), L);
      for (int k = 0; k < beats.size() && k < L; k++) begin
        b = beats[k];
        blen = L - (k / meff) * meff;
        if (blen > meff) blen = meff;
        check("beat_rw", b.rw, rw);
        check("beat_start", b.st, (k % meff) == 0);
        check("beat_len", b.len, blen);
        if (rw) check("beat_wdata", b.data, rb_mem[k]);
      end
      check("rb_count", rb_acc.size(), L);
      for (int k = 0; k < rb_acc.size() && k < L; k++) begin
        check("rb_addr", rb_acc[k][16:8], k);
        check("rb_data", rb_acc[k][7:0], rw ? rb_mem[k] : rd_src[k]);
      end
      check("rd_done", rd_dones, rw ? 0 : 1);
      check("db_err", errs, 0);
      check("hold_stable", stab_err, 0);
      check("idle_low", idle_low, exp_idle);
      if (L > 0) check("first_valid", first_valid - start_cyc, rw ? 3 : 2);
      else check("no_valid", first_valid, -1);
      if (mode == 0) check("waits", waits, 0);
      if (mode == 2) check("stall_waits", waits, stall);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_mon();
    #12;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_txn(4, 4, 1'b1, 0, 0, 1'b1, 1'b0);
    run_txn(5, 2, 1'b0, 0, 0, 1'b1, 1'b0);
    run_txn(3, 0, 1'b1, 0, 0, 1'b1, 1'b0);
    run_txn(0, 3, 1'b0, 0, 0, 1'b1, 1'b0);
`ifdef DB_TIMEOUT_EN
    run_txn(4, 4, 1'b1, 2, 6, 1'b1, 1'b1);
`else
    run_txn(4, 4, 1'b1, 2, 6, 1'b1, 1'b0);
`endif

    // Reset in the middle of a read burst
    @(posedge clk);
    #3;
    clear_mon();
    ready_mode = 0;
    cur_rw = 1'b0;
    rb_db_length = 8'd8;
    rb_db_max_burst_size = 8'd3;
    rb_db_rw = 1'b0;
    rb_db_start = 1'b1;
    @(posedge clk);
    #3;
    rb_db_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("mid_rst_rd_done", rd_dones, 0);
    check("mid_rst_err", errs, 0);
    check("mid_rst_idle", db_rb_idle, 1);
    run_txn(6, 4, 1'b1, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_txn(int'($urandom_range(0, 40)), int'($urandom_range(0, 9)),
              bit'($urandom_range(0, 1)), 1, 0, 1'b0, 1'b0);
    end

    run_txn(255, 255, 1'b1, 0, 0, 1'b0, 1'b0);
    run_txn(255, 0, 1'b0, 1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
